// File: rtl/uart_word_tx_pkg.sv
// Shared definitions for the debug UART word transmitter: defaults, state encodings, command codes.
// Optional build macro: UART_WORD_TX_PARITY_EN (adds an even-parity bit to every character).
package uart_word_tx_pkg;

  localparam int DEFAULT_NUM_BYTES    = 4;
  localparam int DEFAULT_DATA_BITS    = 8;
  localparam int DEFAULT_OVERSAMPLING = 16;
  localparam int DEFAULT_STOP_TICKS   = 16;

  // Debug command bytes, kept here so rx, tx and the debug unit agree.
  localparam logic [7:0] CMD_LOAD       = 8'h01;
  localparam logic [7:0] CMD_CONTINUOUS = 8'h04;

  typedef enum logic [2:0] {
    TX_IDLE   = 3'd0,
    TX_START  = 3'd1,
    TX_DATA   = 3'd2,
    TX_PARITY = 3'd3,
    TX_STOP   = 3'd4
  } tx_state_e;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_SEND = 2'd1,
    W_DONE = 2'd2
  } word_state_e;

  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// Single-character UART engine: START / DATA (LSB first) / [PARITY] / STOP, paced by i_tick.
// Optional build macro: UART_WORD_TX_PARITY_EN (even parity between the data bits and the stop bit).
module uart_tx_byte
  import uart_word_tx_pkg::*;
#(
  parameter int DATA_BITS    = DEFAULT_DATA_BITS,
  parameter int OVERSAMPLING = DEFAULT_OVERSAMPLING,
  parameter int STOP_TICKS   = DEFAULT_STOP_TICKS
) (
  input  logic       clk,
  input  logic       i_rst,
  input  logic       i_tick,
  input  logic       i_start,
  input  logic [7:0] i_byte,
  output logic       o_tx,
  output logic       o_done
);

  localparam int TICK_W = cnt_width(max_int(OVERSAMPLING, STOP_TICKS));
  localparam int BIT_W  = cnt_width(DATA_BITS);

  localparam logic [TICK_W-1:0] OS_LAST   = TICK_W'(OVERSAMPLING - 1);
  localparam logic [TICK_W-1:0] STOP_LAST = TICK_W'(STOP_TICKS - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS - 1);

  tx_state_e         state_q, state_d;
  logic [TICK_W-1:0] tick_cnt_q, tick_cnt_d;
  logic [BIT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]        shift_q, shift_d;
  logic              tx_q, tx_d;
`ifdef UART_WORD_TX_PARITY_EN
  logic              parity_q, parity_d;
`endif

  logic os_end;
  logic stop_end;
  logic load;

  assign os_end   = i_tick && (tick_cnt_q == OS_LAST);
  assign stop_end = (state_q == TX_STOP) && i_tick && (tick_cnt_q == STOP_LAST);
  // A new character may start from idle or on the very tick the stop bit ends (no idle gap).
  assign load     = i_start && ((state_q == TX_IDLE) || stop_end);

  assign o_tx   = tx_q;
  assign o_done = stop_end;

  always_comb begin
    state_d    = state_q;
    tick_cnt_d = tick_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    tx_d       = tx_q;
`ifdef UART_WORD_TX_PARITY_EN
    parity_d   = parity_q;
`endif

    case (state_q)
      TX_IDLE: begin
        tx_d = 1'b1;
      end
      TX_START: begin
        if (i_tick) begin
          if (os_end) begin
            tick_cnt_d = '0;
            bit_cnt_d  = '0;
            state_d    = TX_DATA;
            tx_d       = shift_q[0];
          end else begin
            tick_cnt_d = tick_cnt_q + TICK_W'(1);
          end
        end
      end
      TX_DATA: begin
        if (i_tick) begin
          if (os_end) begin
            tick_cnt_d = '0;
            if (bit_cnt_q == BIT_LAST) begin
`ifdef UART_WORD_TX_PARITY_EN
              state_d = TX_PARITY;
              tx_d    = parity_q;
`else
              state_d = TX_STOP;
              tx_d    = 1'b1;
`endif
            end else begin
              bit_cnt_d = bit_cnt_q + BIT_W'(1);
              shift_d   = {1'b0, shift_q[7:1]};
              tx_d      = shift_q[1];
            end
          end else begin
            tick_cnt_d = tick_cnt_q + TICK_W'(1);
          end
        end
      end
`ifdef UART_WORD_TX_PARITY_EN
      TX_PARITY: begin
        if (i_tick) begin
          if (os_end) begin
            tick_cnt_d = '0;
            state_d    = TX_STOP;
            tx_d       = 1'b1;
          end else begin
            tick_cnt_d = tick_cnt_q + TICK_W'(1);
          end
        end
      end
`endif
      TX_STOP: begin
        if (i_tick) begin
          if (stop_end) begin
            tick_cnt_d = '0;
            state_d    = TX_IDLE;
            tx_d       = 1'b1;
          end else begin
            tick_cnt_d = tick_cnt_q + TICK_W'(1);
          end
        end
      end
      default: begin
        state_d = TX_IDLE;
        tx_d    = 1'b1;
      end
    endcase

    if (load) begin
      state_d    = TX_START;
      tick_cnt_d = '0;
      bit_cnt_d  = '0;
      shift_d    = i_byte;
      tx_d       = 1'b0;
`ifdef UART_WORD_TX_PARITY_EN
      parity_d   = ^i_byte[DATA_BITS-1:0];
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (i_rst) begin
      state_q    <= TX_IDLE;
      tick_cnt_q <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      tx_q       <= 1'b1;
`ifdef UART_WORD_TX_PARITY_EN
      parity_q   <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      tick_cnt_q <= tick_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      tx_q       <= tx_d;
`ifdef UART_WORD_TX_PARITY_EN
      parity_q   <= parity_d;
`endif
    end
  end

endmodule

// File: rtl/uart_word_tx.sv
// Debug UART word transmitter: sends NUM_BYTES-byte words MSB byte first through uart_tx_byte.
// Optional build macro: UART_WORD_TX_PARITY_EN (passed through to the character engine).
module uart_word_tx
  import uart_word_tx_pkg::*;
#(
  parameter int NUM_BYTES    = DEFAULT_NUM_BYTES,
  parameter int DATA_BITS    = DEFAULT_DATA_BITS,
  parameter int OVERSAMPLING = DEFAULT_OVERSAMPLING,
  parameter int STOP_TICKS   = DEFAULT_STOP_TICKS
) (
  input  logic                   clk,
  input  logic                   i_rst,
  input  logic                   i_tick,
  input  logic [8*NUM_BYTES-1:0] i_word,
  input  logic                   i_valid,
  output logic                   o_ready,
  output logic                   o_busy,
  output logic                   o_done,
  output logic                   o_tx
);

  localparam int WORD_W = 8 * NUM_BYTES;
  localparam int BYTE_W = cnt_width(NUM_BYTES);
  localparam logic [BYTE_W-1:0] BYTE_LAST = BYTE_W'(NUM_BYTES - 1);

  word_state_e       state_q, state_d;
  logic [WORD_W-1:0] word_q, word_d;
  logic [BYTE_W-1:0] byte_cnt_q, byte_cnt_d;

  logic              byte_start;
  logic [7:0]        byte_data;
  logic              byte_done;
  logic [WORD_W-1:0] word_shifted;

  // The word register is shifted left per byte, so the next byte is always at the top.
  assign word_shifted = word_q << 8;

  assign o_ready = (state_q == W_IDLE);
  assign o_busy  = (state_q != W_IDLE);
  assign o_done  = (state_q == W_DONE);

  always_comb begin
    state_d    = state_q;
    word_d     = word_q;
    byte_cnt_d = byte_cnt_q;
    byte_start = 1'b0;
    byte_data  = word_q[WORD_W-1 -: 8];

    case (state_q)
      W_IDLE: begin
        if (i_valid) begin
          word_d     = i_word;
          byte_cnt_d = '0;
          byte_start = 1'b1;
          byte_data  = i_word[WORD_W-1 -: 8];
          state_d    = W_SEND;
        end
      end
      W_SEND: begin
        if (byte_done) begin
          if (byte_cnt_q < BYTE_LAST) begin
            byte_cnt_d = byte_cnt_q + BYTE_W'(1);
            word_d     = word_shifted;
            byte_data  = word_shifted[WORD_W-1 -: 8];
            byte_start = 1'b1;
          end else begin
            state_d = W_DONE;
          end
        end
      end
      W_DONE: begin
        state_d = W_IDLE;
      end
      default: begin
        state_d = W_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (i_rst) begin
      state_q    <= W_IDLE;
      word_q     <= '0;
      byte_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      word_q     <= word_d;
      byte_cnt_q <= byte_cnt_d;
    end
  end

  uart_tx_byte #(
    .DATA_BITS   (DATA_BITS),
    .OVERSAMPLING(OVERSAMPLING),
    .STOP_TICKS  (STOP_TICKS)
  ) u_tx_byte (
    .clk    (clk),
    .i_rst  (i_rst),
    .i_tick (i_tick),
    .i_start(byte_start),
    .i_byte (byte_data),
    .o_tx   (o_tx),
    .o_done (byte_done)
  );

endmodule

// File: tb/tb_uart_word_tx.sv
// Directed self-checking bench for uart_word_tx; an independent line decoder recovers the sent bytes.
// Honours UART_WORD_TX_PARITY_EN to expect the parity bit and the longer word.
module tb_uart_word_tx;

`ifdef UART_WORD_TX_PARITY_EN
  localparam int WORD_TICKS = 704;
`else
  localparam int WORD_TICKS = 640;
`endif

  logic        clk;
  logic        i_rst;
  logic        i_tick;
  logic [31:0] i_word;
  logic        i_valid;
  logic        o_ready;
  logic        o_busy;
  logic        o_done;
  logic        o_tx;

  int checks = 0;
  int errors = 0;
  int done_count = 0;
  int framing_errs = 0;
  int tick_div = 0;

  logic [7:0] rx_q[$];
  logic       par_q[$];
  int         rx_state = 0;
  int         rx_cnt = 0;
  int         rx_bits = 0;
  logic [7:0] rx_byte = 8'h00;

  uart_word_tx dut (
    .clk    (clk),
    .i_rst  (i_rst),
    .i_tick (i_tick),
    .i_word (i_word),
    .i_valid(i_valid),
    .o_ready(o_ready),
    .o_busy (o_busy),
    .o_done (o_done),
    .o_tx   (o_tx)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Baud tick: one clk wide, every 4th clk, changed on the falling edge.
  initial begin
    i_tick = 1'b0;
    forever begin
      @(negedge clk);
      tick_div = (tick_div == 3) ? 0 : tick_div + 1;
      i_tick = (tick_div == 3);
    end
  end

  // Line decoder: samples mid-bit (8 ticks into start, then every 16 ticks) and counts o_done pulses.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (i_rst) begin
        rx_state = 0;
        rx_cnt = 0;
      end else begin
        if (o_done) done_count++;
        case (rx_state)
          0: if (o_tx == 1'b0) begin rx_state = 1; rx_cnt = 0; end
          1: if (i_tick) begin
               rx_cnt++;
               if (rx_cnt == 8) begin
                 if (o_tx != 1'b0) rx_state = 0;
                 else begin rx_state = 2; rx_cnt = 0; rx_bits = 0; rx_byte = 8'h00; end
               end
             end
          2: if (i_tick) begin
               rx_cnt++;
               if (rx_cnt == 16) begin
                 rx_cnt = 0;
                 rx_byte = {o_tx, rx_byte[7:1]};
                 rx_bits++;
`ifdef UART_WORD_TX_PARITY_EN
                 if (rx_bits == 8) rx_state = 3;
`else
                 if (rx_bits == 8) rx_state = 4;
`endif
               end
             end
          3: if (i_tick) begin
               rx_cnt++;
               if (rx_cnt == 16) begin rx_cnt = 0; par_q.push_back(o_tx); rx_state = 4; end
             end
          4: if (i_tick) begin
               rx_cnt++;
               if (rx_cnt == 16) begin
                 if (o_tx != 1'b1) framing_errs++;
                 rx_q.push_back(rx_byte);
                 rx_state = 0;
               end
             end
          default: rx_state = 0;
        endcase
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [31:0] w, input bit hold);
    bit got_ready;
    got_ready = 1'b0;
    @(negedge clk);
    i_word = w;
    i_valid = 1'b1;
    for (int c = 0; c < 6000; c++) begin
      if (o_ready) begin got_ready = 1'b1; break; end
      @(negedge clk);
    end
    if (!got_ready) checkOutput("ready_timeout", 64'd1, 64'd0);
    @(posedge clk);
    #1;
    if (!hold) i_valid = 1'b0;
  endtask

  task automatic waitDone(output int ticks);
    ticks = 0;
    for (int c = 0; c < 6000; c++) begin
      @(posedge clk);
      #1;
      if (i_tick) ticks++;
      if (o_done) return;
    end
    checkOutput("done_timeout", 64'd1, 64'd0);
  endtask

  task automatic waitTicks(input int n);
    int k;
    k = 0;
    for (int c = 0; c < 20 * n + 20 && k < n; c++) begin
      @(posedge clk);
      #1;
      if (i_tick) k++;
    end
  endtask

  task automatic checkBytes(input string tag, input logic [63:0] exp, input int n);
    checkOutput({tag, "_count"}, 64'(rx_q.size()), 64'(n));
    for (int i = 0; i < n && i < rx_q.size(); i++)
      checkOutput($sformatf("%s_byte%0d", tag, i), 64'(rx_q[i]), 64'(exp[8*n-1-8*i -: 8]));
  endtask

  initial begin
    int ticks;
    int dc0;
    int activity;

    i_rst = 1'b1;
    i_valid = 1'b0;
    i_word = 32'h0;
    repeat (3) @(negedge clk);
    i_rst = 1'b0;
    checkOutput("rst_tx", 64'(o_tx), 64'd1);
    checkOutput("rst_ready", 64'(o_ready), 64'd1);
    checkOutput("rst_busy", 64'(o_busy), 64'd0);
    checkOutput("rst_done", 64'(o_done), 64'd0);

    activity = 0;
    ticks = 0;
    for (int c = 0; c < 5000 && ticks < 1000; c++) begin
      @(posedge clk);
      #1;
      if (i_tick) ticks++;
      if (o_tx !== 1'b1 || o_busy !== 1'b0 || o_done !== 1'b0 || o_ready !== 1'b1) activity++;
    end
    checkOutput("idle_activity", 64'(activity), 64'd0);
    checkOutput("idle_rx_count", 64'(rx_q.size()), 64'd0);

    rx_q.delete();
    dc0 = done_count;
    applyStimulus(32'h2001000F, 1'b0);
    checkOutput("w1_busy", 64'(o_busy), 64'd1);
    checkOutput("w1_start_tx", 64'(o_tx), 64'd0);
    waitDone(ticks);
    checkOutput("w1_ticks", 64'(ticks), 64'(WORD_TICKS));
    repeat (3) @(negedge clk);
    checkBytes("w1", 64'h2001000F, 4);
    checkOutput("w1_done_pulses", 64'(done_count - dc0), 64'd1);

    rx_q.delete();
    dc0 = done_count;
    applyStimulus(32'hFFFFFFFF, 1'b1);
    i_word = 32'h00000000;
    waitDone(ticks);
    checkOutput("b2b_first_ticks", 64'(ticks), 64'(WORD_TICKS));
    @(posedge clk);
    #1;
    checkOutput("b2b_ready_rise", 64'(o_ready), 64'd1);
    checkOutput("b2b_gap_tx", 64'(o_tx), 64'd1);
    @(posedge clk);
    #1;
    checkOutput("b2b_second_start", 64'(o_tx), 64'd0);
    checkOutput("b2b_second_busy", 64'(o_busy), 64'd1);
    i_valid = 1'b0;
    waitDone(ticks);
    checkOutput("b2b_second_ticks", 64'(ticks), 64'(WORD_TICKS));
    repeat (3) @(negedge clk);
    checkBytes("b2b", 64'hFFFFFFFF_00000000, 8);
    checkOutput("b2b_done_pulses", 64'(done_count - dc0), 64'd2);

    rx_q.delete();
    dc0 = done_count;
    applyStimulus(32'hCAFEBABE, 1'b0);
    waitTicks(300);
    @(negedge clk);
    i_word = 32'h12345678;
    i_valid = 1'b1;
    @(negedge clk);
    i_valid = 1'b0;
    waitDone(ticks);
    repeat (100) @(negedge clk);
    checkOutput("ignore_busy_after", 64'(o_busy), 64'd0);
    checkOutput("ignore_ready_after", 64'(o_ready), 64'd1);
    checkBytes("ignore", 64'hCAFEBABE, 4);
    checkOutput("ignore_done_pulses", 64'(done_count - dc0), 64'd1);

    rx_q.delete();
    dc0 = done_count;
    applyStimulus(32'h11223344, 1'b0);
    waitTicks(216);
    @(negedge clk);
    i_rst = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("midrst_tx", 64'(o_tx), 64'd1);
    checkOutput("midrst_busy", 64'(o_busy), 64'd0);
    checkOutput("midrst_ready", 64'(o_ready), 64'd1);
    checkOutput("midrst_done", 64'(o_done), 64'd0);
    @(negedge clk);
    i_rst = 1'b0;
    waitTicks(800);
    @(negedge clk);
    checkOutput("midrst_no_done", 64'(done_count - dc0), 64'd0);
    checkBytes("midrst_partial", 64'h11, 1);

    rx_q.delete();
    dc0 = done_count;
    applyStimulus(32'h00000004, 1'b0);
    waitDone(ticks);
    checkOutput("after_rst_ticks", 64'(ticks), 64'(WORD_TICKS));
    repeat (3) @(negedge clk);
    checkBytes("after_rst", 64'h00000004, 4);
    checkOutput("after_rst_done_pulses", 64'(done_count - dc0), 64'd1);

`ifdef UART_WORD_TX_PARITY_EN
    rx_q.delete();
    par_q.delete();
    applyStimulus(32'h01030700, 1'b0);
    waitDone(ticks);
    checkOutput("par_ticks", 64'(ticks), 64'd704);
    repeat (3) @(negedge clk);
    checkBytes("par", 64'h01030700, 4);
    checkOutput("par_bit_count", 64'(par_q.size()), 64'd4);
    if (par_q.size() == 4)
      checkOutput("par_bits", 64'({par_q[0], par_q[1], par_q[2], par_q[3]}), 64'b1010);
`endif

    checkOutput("framing_errors", 64'(framing_errs), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
